// File: rtl/vga_timing_gen.sv
// Raster timing source: scan counters plus registered sync, data-enable and
// line/frame/vblank strobes, all aligned to the same (DrawX, DrawY).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       vde,
  output logic       line_start,
  output logic       frame_start,
  output logic       vblank_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] x_r, y_r, x_nx_s, y_nx_s;
  logic       hs_r, vs_r, vde_r, ls_r, fs_r, vb_r;
  logic       hs_nx_s, vs_nx_s, vde_nx_s, ls_nx_s, fs_nx_s, vb_nx_s;
  logic [7:0] fc_r, fc_nx_s;

  // Next-state counters and decodes; outputs are decoded from the next
  // position so they register in step with DrawX/DrawY.
  always_comb begin
    x_nx_s  = x_r;
    y_nx_s  = y_r;
    ls_nx_s = 1'b0;
    fs_nx_s = 1'b0;
    vb_nx_s = 1'b0;
    fc_nx_s = fc_r;
    if (pix_en) begin
      if (x_r == H_LAST) begin
        x_nx_s = 10'd0;
        if (y_r == V_LAST) begin
          y_nx_s = 10'd0;
        end else begin
          y_nx_s = y_r + 10'd1;
        end
      end else begin
        x_nx_s = x_r + 10'd1;
      end
      ls_nx_s = (x_nx_s == 10'd0);
      fs_nx_s = (x_nx_s == 10'd0) && (y_nx_s == 10'd0);
      vb_nx_s = (x_nx_s == 10'd0) && (y_nx_s == V_ACT);
      if (fs_nx_s) begin
        fc_nx_s = fc_r + 8'd1;
      end else begin
        fc_nx_s = fc_r;
      end
    end else begin
      x_nx_s = x_r;
    end
    hs_nx_s  = ((x_nx_s >= HS_BEG) && (x_nx_s < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vs_nx_s  = ((y_nx_s >= VS_BEG) && (y_nx_s < VS_END)) ? SYNC_POL : ~SYNC_POL;
    vde_nx_s = (x_nx_s < H_ACT) && (y_nx_s < V_ACT);
  end

  // State and output registers; reset parks the scan on the last pixel so
  // the first enabled edge lands on (0,0).
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      x_r   <= H_LAST;
      y_r   <= V_LAST;
      hs_r  <= ~SYNC_POL;
      vs_r  <= ~SYNC_POL;
      vde_r <= 1'b0;
      ls_r  <= 1'b0;
      fs_r  <= 1'b0;
      vb_r  <= 1'b0;
      fc_r  <= 8'd0;
    end else begin
      x_r   <= x_nx_s;
      y_r   <= y_nx_s;
      hs_r  <= hs_nx_s;
      vs_r  <= vs_nx_s;
      vde_r <= vde_nx_s;
      ls_r  <= ls_nx_s;
      fs_r  <= fs_nx_s;
      vb_r  <= vb_nx_s;
      fc_r  <= fc_nx_s;
    end
  end

  assign DrawX        = x_r;
  assign DrawY        = y_r;
  assign hs           = hs_r;
  assign vs           = vs_r;
  assign vde          = vde_r;
  assign line_start   = ls_r;
  assign frame_start  = fs_r;
  assign vblank_start = vb_r;
  assign frame_count  = fc_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a shrunken raster (16x10) for whole-frame
// and wrap behaviour, plus a default-parameter instance for line-0 timing.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic pix_en = 1'b0;

  logic [9:0] s_x, s_y, f_x, f_y;
  logic s_hs, s_vs, s_vde, s_ls, s_fs, s_vb;
  logic f_hs, f_vs, f_vde, f_ls, f_fs, f_vb;
  logic [7:0] s_fc, f_fc;

  int checks = 0;
  int failures = 0;

  // model of the small raster: H 8/2/3/3 (16), V 6/1/2/1 (10)
  int mx = 15, my = 9, mfc = 0;
  logic mls = 1'b0, mfs = 1'b0, mvb = 1'b0;

  always #5 Clk = ~Clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) u_small (
    .Clk(Clk), .Reset_n(Reset_n), .pix_en(pix_en),
    .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs), .vde(s_vde),
    .line_start(s_ls), .frame_start(s_fs), .vblank_start(s_vb),
    .frame_count(s_fc)
  );

  vga_timing_gen u_full (
    .Clk(Clk), .Reset_n(Reset_n), .pix_en(pix_en),
    .DrawX(f_x), .DrawY(f_y), .hs(f_hs), .vs(f_vs), .vde(f_vde),
    .line_start(f_ls), .frame_start(f_fs), .vblank_start(f_vb),
    .frame_count(f_fc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic en, input logic rst_n);
    if (!rst_n) begin
      mx = 15; my = 9; mfc = 0; mls = 1'b0; mfs = 1'b0; mvb = 1'b0;
    end else if (en) begin
      if (mx == 15) begin
        mx = 0;
        my = (my == 9) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      mls = (mx == 0);
      mfs = (mx == 0) && (my == 0);
      mvb = (mx == 0) && (my == 6);
      if (mfs) mfc = (mfc + 1) % 256;
    end else begin
      mls = 1'b0; mfs = 1'b0; mvb = 1'b0;
    end
  endtask

  // one Clk edge with the given enable; small instance checked against the model
  task automatic step(input logic en);
    logic ehs, evs, evde;
    pix_en = en;
    @(posedge Clk);
    model_update(en, Reset_n);
    #1;
    ehs  = !((mx >= 10) && (mx < 13));
    evs  = !((my >= 7) && (my < 9));
    evde = (mx < 8) && (my < 6);
    chk("small_align",
        {30'd0, s_x, s_y, s_hs, s_vs, s_vde, s_ls, s_fs, s_vb, s_fc},
        {30'd0, 10'(mx), 10'(my), ehs, evs, evde, mls, mfs, mvb, 8'(mfc)});
  endtask

  initial begin
    int n, lines, vdes, vslow, vbs, fsn, hsl, hs_first, hs_last, vsl_f, vde_f;
    logic found, saw255, wrapped;
    logic [9:0] px, py;
    logic [3:0] pat;

    // reset with pix_en low
    Reset_n = 1'b0;
    step(1'b0);
    chk("rst_small_xy", {s_x, s_y}, {10'd15, 10'd9});
    chk("rst_full_xy", {f_x, f_y}, {10'd799, 10'd524});
    chk("rst_full_sync", {f_hs, f_vs, f_vde}, 3'b110);
    chk("rst_full_strobes", {f_ls, f_fs, f_vb, f_fc}, 11'd0);

    // first enabled edge lands on (0,0)
    Reset_n = 1'b1;
    step(1'b1);
    chk("first_full_xy", {f_x, f_y}, 20'd0);
    chk("first_full_flags", {f_vde, f_fs, f_ls, f_vb, f_hs, f_vs}, 6'b111011);
    chk("first_full_fc", f_fc, 8'd1);
    chk("first_small_flags", {s_vde, s_fs, s_ls, s_fc}, {3'b111, 8'd1});

    // rest of line 0 on the full-size instance
    hsl = 0; hs_first = -1; hs_last = -1; vsl_f = 0; vde_f = 1;
    for (int i = 1; i < 800; i++) begin
      step(1'b1);
      chk("full_line0_x", {f_x, f_y}, {10'(i), 10'd0});
      if (!f_hs) begin
        hsl++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      if (!f_vs) vsl_f++;
      if (f_vde) vde_f++;
    end
    chk("full_hs_low_cnt", 64'(hsl), 64'd96);
    chk("full_hs_first", 64'(hs_first), 64'd656);
    chk("full_hs_last", 64'(hs_last), 64'd751);
    chk("full_vs_line0", 64'(vsl_f), 64'd0);
    chk("full_vde_line0", 64'(vde_f), 64'd640);
    step(1'b1);
    chk("full_line1", {f_x, f_y, f_ls, f_fs}, {10'd0, 10'd1, 2'b10});

    // one whole small frame with continuous enable
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b1);
      found = s_fs;
    end
    chk("sync_frame", found, 1'b1);
    n = 0; lines = 0; vdes = 0; vslow = 0; vbs = 0; found = 1'b0;
    while (!found && n < 400) begin
      step(1'b1);
      n++;
      if (s_ls) lines++;
      if (s_vde) vdes++;
      if (!s_vs) vslow++;
      if (s_vb) begin
        vbs++;
        chk("vblank_pos", {s_x, s_y, s_ls}, {10'd0, 10'd6, 1'b1});
      end
      found = s_fs;
    end
    chk("frame_period", 64'(n), 64'd160);
    chk("lines_per_frame", 64'(lines), 64'd10);
    chk("vde_per_frame", 64'(vdes), 64'd48);
    chk("vs_low_per_frame", 64'(vslow), 64'd32);
    chk("vblank_per_frame", 64'(vbs), 64'd1);

    // divide-by-2 enable: 320 Clk between frames, one-cycle frame_start
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(1'b1);
      found = s_fs;
      if (!found) step(1'b0);
    end
    chk("sync_div2", found, 1'b1);
    step(1'b0);
    chk("fs_one_cycle", {s_fs, s_ls}, 2'b00);
    n = 1; fsn = 0; found = 1'b0;
    while (!found && n < 700) begin
      step(1'b1);
      n++;
      if (s_fs) fsn++;
      found = s_fs;
      if (!found) begin
        step(1'b0);
        n++;
        if (s_fs) fsn++;
      end
    end
    chk("div2_period", 64'(n), 64'd320);
    chk("div2_fs_cycles", 64'(fsn), 64'd1);

    // irregular enable pattern
    pat = 4'b1001;
    for (int i = 0; i < 64; i++) begin
      for (int j = 3; j >= 0; j--) step(pat[j]);
    end

    // frame_count wrap 255 -> 0, with both counters wrapping on that edge
    saw255 = 1'b0; wrapped = 1'b0;
    for (int i = 0; i < 45000 && !wrapped; i++) begin
      px = s_x; py = s_y;
      step(1'b1);
      if (s_fs && s_fc == 8'd255) saw255 = 1'b1;
      if (s_fs && s_fc == 8'd0) begin
        wrapped = 1'b1;
        chk("wrap_prev_xy", {px, py}, {10'd15, 10'd9});
      end
    end
    chk("fc_saw_255", saw255, 1'b1);
    chk("fc_wrapped", wrapped, 1'b1);

    // mid-frame reset with pix_en high
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b1);
      found = (s_x == 10'd5) && (s_y == 10'd3);
    end
    chk("reach_mid", found, 1'b1);
    Reset_n = 1'b0;
    step(1'b1);
    chk("mid_rst_small", {s_x, s_y, s_vde, s_hs, s_vs, s_fc}, {10'd15, 10'd9, 3'b011, 8'd0});
    chk("mid_rst_full", {f_x, f_y, f_vde, f_hs, f_vs, f_fc}, {10'd799, 10'd524, 3'b011, 8'd0});
    Reset_n = 1'b1;
    step(1'b1);
    chk("restart_full", {f_x, f_y, f_vde, f_fs, f_ls, f_fc}, {20'd0, 3'b111, 8'd1});
    chk("restart_small", {s_x, s_y, s_fs, s_fc}, {20'd0, 1'b1, 8'd1});
    step(1'b1);
    chk("restart_fs_drop", {s_fs, f_fs, s_x, f_x}, {2'b00, 10'd1, 10'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
